// File: rtl/qf_soc_pkg.sv
// qf_soc_pkg: shared RV32I decode constants, ALU operation enum and the
// MMIO region nibble used by the qf_soc core.
package qf_soc_pkg;

  localparam int DATA_W = 32;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [3:0] MMIO_REGION = 4'h1;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // instr[30] selects SUB only for register-register ops; it selects SRA for both.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic is_op);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/qf_soc_core.sv
// qf_soc_core: single-cycle RV32I core (fetch, decode, ALU, regfile, LSU).
// Optional MMIO store region enabled by defining QF_SOC_MMIO_EN.
module qf_soc_core
  import qf_soc_pkg::*;
#(
  parameter int          ITCM_AW  = 10,
  parameter int          DTCM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ITCM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_rdata,
  output logic [DTCM_AW-1:0] o_dmem_addr,
  input  logic [31:0]        i_dmem_rdata,
  output logic               o_dmem_we,
  output logic [3:0]         o_dmem_be,
  output logic [31:0]        o_dmem_wdata,
  output logic [31:0]        o_dbg_pc,
  output logic               o_mmio_we,
  output logic [31:0]        o_mmio_addr,
  output logic [31:0]        o_mmio_wdata
);

  logic [31:0] r_pc;
  logic [31:0] rf [0:31];

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic signed [31:0] w_rs1_s, w_rs2_s;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_lsu_addr;
  logic [31:0] w_ld_bshift, w_ld_hshift;
  logic        w_mmio_hit;
  logic        w_br_taken;
  logic        w_rf_we;
  logic [31:0] w_rd_data;
  logic [31:0] w_next_pc;
  logic        w_store_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      default:  y = a & b;
    endcase
    return y;
  endfunction

  assign o_imem_addr = r_pc[ITCM_AW+1:2];
  assign w_instr     = i_imem_rdata;
  assign w_opcode    = w_instr[6:0];
  assign w_rd        = w_instr[11:7];
  assign w_f3        = w_instr[14:12];
  assign w_rs1       = w_instr[19:15];
  assign w_rs2       = w_instr[24:20];

  assign w_imm_i = {{21{w_instr[31]}}, w_instr[30:20]};
  assign w_imm_s = {{21{w_instr[31]}}, w_instr[30:25], w_instr[11:7]};
  assign w_imm_b = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : rf[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : rf[w_rs2];
  assign w_rs1_s    = w_rs1_val;
  assign w_rs2_s    = w_rs2_val;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign w_lsu_addr  = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign o_dmem_addr = w_lsu_addr[DTCM_AW+1:2];
  assign w_ld_bshift = i_dmem_rdata >> {w_lsu_addr[1:0], 3'b000};
  assign w_ld_hshift = i_dmem_rdata >> {w_lsu_addr[1], 4'b0000};

`ifdef QF_SOC_MMIO_EN
  assign w_mmio_hit   = (w_lsu_addr[31:28] == MMIO_REGION);
  assign o_mmio_we    = (w_opcode == OP_STORE) && w_store_ok && w_mmio_hit && !rst;
  assign o_mmio_addr  = w_lsu_addr;
  assign o_mmio_wdata = w_rs2_val;
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^w_lsu_addr[31:DTCM_AW+2];
  assign w_mmio_hit       = 1'b0;
  assign o_mmio_we        = 1'b0;
  assign o_mmio_addr      = 32'd0;
  assign o_mmio_wdata     = 32'd0;
`endif

  // Branch condition evaluation
  always_comb begin
    case (w_f3)
      F3_BEQ:  w_br_taken = (w_rs1_val == w_rs2_val);
      F3_BNE:  w_br_taken = (w_rs1_val != w_rs2_val);
      F3_BLT:  w_br_taken = (w_rs1_s < w_rs2_s);
      F3_BGE:  w_br_taken = (w_rs1_s >= w_rs2_s);
      F3_BLTU: w_br_taken = (w_rs1_val < w_rs2_val);
      F3_BGEU: w_br_taken = (w_rs1_val >= w_rs2_val);
      default: w_br_taken = 1'b0;
    endcase
  end

  // Decode/execute: writeback value, next PC and store lane formatting
  always_comb begin
    w_rf_we    = 1'b0;
    w_rd_data  = 32'd0;
    w_next_pc  = w_pc_plus4;
    w_store_ok = 1'b0;
    w_be       = 4'b0000;
    w_wdata    = 32'd0;
    case (w_opcode)
      OP_LUI:   begin w_rf_we = 1'b1; w_rd_data = w_imm_u; end
      OP_AUIPC: begin w_rf_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
      OP_JAL: begin
        w_rf_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        w_rf_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      OP_BRANCH: if (w_br_taken) w_next_pc = r_pc + w_imm_b;
      OP_LOAD: begin
        w_rf_we = 1'b1;
        case (w_f3)
          F3_LB:   w_rd_data = {{24{w_ld_bshift[7]}}, w_ld_bshift[7:0]};
          F3_LH:   w_rd_data = {{16{w_ld_hshift[15]}}, w_ld_hshift[15:0]};
          F3_LW:   w_rd_data = i_dmem_rdata;
          F3_LBU:  w_rd_data = {24'd0, w_ld_bshift[7:0]};
          F3_LHU:  w_rd_data = {16'd0, w_ld_hshift[15:0]};
          default: w_rf_we = 1'b0;
        endcase
        if (w_mmio_hit) w_rd_data = 32'd0;
      end
      OP_STORE: begin
        w_store_ok = 1'b1;
        case (w_f3)
          F3_SB: begin
            w_be    = 4'b0001 << w_lsu_addr[1:0];
            w_wdata = {4{w_rs2_val[7:0]}};
          end
          F3_SH: begin
            w_be    = w_lsu_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_rs2_val[15:0]}};
          end
          F3_SW: begin
            w_be    = 4'b1111;
            w_wdata = w_rs2_val;
          end
          default: w_store_ok = 1'b0;
        endcase
      end
      OP_IMM: begin
        w_rf_we   = 1'b1;
        w_rd_data = alu_exec(alu_decode(w_f3, w_instr[30], 1'b0), w_rs1_val, w_imm_i);
      end
      OP_OP: begin
        w_rf_we   = 1'b1;
        w_rd_data = alu_exec(alu_decode(w_f3, w_instr[30], 1'b1), w_rs1_val, w_rs2_val);
      end
      default: ;
    endcase
  end

  // A store coinciding with reset must not reach memory
  assign o_dmem_we    = w_store_ok && !w_mmio_hit && !rst;
  assign o_dmem_be    = w_be;
  assign o_dmem_wdata = w_wdata;
  assign o_dbg_pc     = r_pc;

  // Program counter update
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end

  // Register file writeback; x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (w_rf_we && (w_rd != 5'd0)) begin
      rf[w_rd] <= w_rd_data;
    end
  end

endmodule

// File: rtl/qf_soc_tcm.sv
// qf_tcm: word-organised tightly-coupled memory with a combinational read
// port and a byte-enabled synchronous write port. No reset: contents persist.
module qf_tcm #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic [AW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [DW/8-1:0] i_be,
  input  logic [DW-1:0]   i_wdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign o_rdata = mem[i_raddr];

  // Byte-lane write; lanes without an enable keep their old contents
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_be[b]) mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/qf_soc.sv
// qf_soc: minimal RV32I SoC top -- single-cycle core with instruction and
// data TCMs. Define QF_SOC_MMIO_EN to route stores in 0x1xxx_xxxx to MMIO.
module qf_soc
  import qf_soc_pkg::*;
#(
  parameter int          ITCM_AW  = 10,
  parameter int          DTCM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dbg_pc,
  output logic        mmio_we,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata
);

  logic [ITCM_AW-1:0] w_imem_addr;
  logic [31:0]        w_imem_rdata;
  logic [DTCM_AW-1:0] w_dmem_addr;
  logic [31:0]        w_dmem_rdata;
  logic               w_dmem_we;
  logic [3:0]         w_dmem_be;
  logic [31:0]        w_dmem_wdata;

  qf_soc_core #(
    .ITCM_AW  (ITCM_AW),
    .DTCM_AW  (DTCM_AW),
    .RESET_PC (RESET_PC)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .o_imem_addr  (w_imem_addr),
    .i_imem_rdata (w_imem_rdata),
    .o_dmem_addr  (w_dmem_addr),
    .i_dmem_rdata (w_dmem_rdata),
    .o_dmem_we    (w_dmem_we),
    .o_dmem_be    (w_dmem_be),
    .o_dmem_wdata (w_dmem_wdata),
    .o_dbg_pc     (dbg_pc),
    .o_mmio_we    (mmio_we),
    .o_mmio_addr  (mmio_addr),
    .o_mmio_wdata (mmio_wdata)
  );

  qf_tcm #(.AW(ITCM_AW), .DW(DATA_W)) u_itcm (
    .clk     (clk),
    .i_raddr (w_imem_addr),
    .o_rdata (w_imem_rdata),
    .i_we    (1'b0),
    .i_waddr ({ITCM_AW{1'b0}}),
    .i_be    (4'b0000),
    .i_wdata (32'd0)
  );

  qf_tcm #(.AW(DTCM_AW), .DW(DATA_W)) u_dtcm (
    .clk     (clk),
    .i_raddr (w_dmem_addr),
    .o_rdata (w_dmem_rdata),
    .i_we    (w_dmem_we),
    .i_waddr (w_dmem_addr),
    .i_be    (w_dmem_be),
    .i_wdata (w_dmem_wdata)
  );

endmodule

// File: tb/tb_qf_soc.sv
// tb_qf_soc: directed program tests for qf_soc. Single-instruction ALU
// vectors come from a table; multi-cycle scenarios are hand-written.
module tb_qf_soc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dbg_pc;
  logic        mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qf_soc dut (
    .clk        (clk),
    .rst        (rst),
    .dbg_pc     (dbg_pc),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Enter reset at a falling edge and clear both memories
  task automatic begin_test();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      dut.u_itcm.mem[i] = 32'h0;
      dut.u_dtcm.mem[i] = 32'h0;
    end
  endtask

  // One rising edge with rst high, then release; PC=0 executes next edge
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int mmio_pulses;

  initial begin
    vecs[0]  = '{"add_wrap", 32'h002081B3, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000};
    vecs[1]  = '{"sub",      32'h402081B3, 32'h00000000, 32'h00000001, 5'd3, 32'hFFFFFFFF};
    vecs[2]  = '{"sll_amt5", 32'h002091B3, 32'h00000001, 32'h00000021, 5'd3, 32'h00000002};
    vecs[3]  = '{"slt",      32'h0020A1B3, 32'hFFFFFFFF, 32'h00000001, 5'd3, 32'h00000001};
    vecs[4]  = '{"sltu",     32'h0020B1B3, 32'hFFFFFFFF, 32'h00000001, 5'd3, 32'h00000000};
    vecs[5]  = '{"xor",      32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'h0FF00FF0};
    vecs[6]  = '{"srl",      32'h0020D1B3, 32'h80000000, 32'h00000004, 5'd3, 32'h08000000};
    vecs[7]  = '{"sra",      32'h4020D1B3, 32'h80000000, 32'h00000004, 5'd3, 32'hF8000000};
    vecs[8]  = '{"or",       32'h0020E1B3, 32'hF0F0F0F0, 32'h0F0F0000, 5'd3, 32'hFFFFF0F0};
    vecs[9]  = '{"and",      32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'hF000F000};
    vecs[10] = '{"addi_neg", 32'hFFF08193, 32'h00000000, 32'h00000000, 5'd3, 32'hFFFFFFFF};
    vecs[11] = '{"srai",     32'h4040D193, 32'h80000000, 32'h00000000, 5'd3, 32'hF8000000};
    vecs[12] = '{"slti",     32'h0000A193, 32'hFFFFFFFF, 32'h00000000, 5'd3, 32'h00000001};
    vecs[13] = '{"lui",      32'h123451B7, 32'h00000000, 32'h00000000, 5'd3, 32'h12345000};
    vecs[14] = '{"auipc",    32'h00001197, 32'h00000000, 32'h00000000, 5'd3, 32'h00001000};
    vecs[15] = '{"x0_write", 32'h00208033, 32'h00000005, 32'h00000006, 5'd0, 32'h00000000};
    vecs[16] = '{"ecall_nop",32'h00000073, 32'h00000007, 32'h00000009, 5'd1, 32'h00000007};

    // Reset state: a stale register value must be cleared
    begin_test();
    dut.u_core.rf[5] = 32'h00001234;
    release_rst();
    check("reset_pc", dbg_pc, 32'h0);
    check("reset_x5", dut.u_core.rf[5], 32'h0);
    check("reset_mmio_we", {31'b0, mmio_we}, 32'h0);

    // Table: one instruction at PC 0 with x1/x2 preset
    foreach (vecs[k]) begin
      begin_test();
      dut.u_itcm.mem[0] = vecs[k].instr;
      release_rst();
      dut.u_core.rf[1] = vecs[k].a;
      dut.u_core.rf[2] = vecs[k].b;
      step(1);
      check({vecs[k].name, "_rd"}, dut.u_core.rf[vecs[k].rd], vecs[k].exp);
      check({vecs[k].name, "_pc"}, dbg_pc, 32'h4);
    end

    // Taken branch skips word 4 and lands on word 25
    begin_test();
    dut.u_itcm.mem[0]  = 32'h00100093;
    dut.u_itcm.mem[1]  = 32'h00100113;
    dut.u_itcm.mem[2]  = 32'h01000193;
    dut.u_itcm.mem[3]  = 32'h04208c63;
    dut.u_itcm.mem[4]  = 32'h100137b7;
    dut.u_itcm.mem[25] = 32'h00878793;
    release_rst();
    step(3);
    check("br_pc_before", dbg_pc, 32'h0000000C);
    step(1);
    check("br_pc_target", dbg_pc, 32'h00000064);
    step(6);
    check("br_x1", dut.u_core.rf[1], 32'd1);
    check("br_x2", dut.u_core.rf[2], 32'd1);
    check("br_x3", dut.u_core.rf[3], 32'd16);
    check("br_x15", dut.u_core.rf[15], 32'd8);
    check("br_pc_end", dbg_pc, 32'h0000007C);

    // Load-use with no stall
    begin_test();
    dut.u_dtcm.mem[0] = 32'd5;
    dut.u_itcm.mem[0] = 32'h00000103;
    dut.u_itcm.mem[1] = 32'h00110213;
    release_rst();
    step(2);
    check("lu_x2", dut.u_core.rf[2], 32'd5);
    check("lu_x4", dut.u_core.rf[4], 32'd6);

    // Byte and halfword stores/loads
    begin_test();
    dut.u_dtcm.mem[0] = 32'h11223344;
    dut.u_itcm.mem[0] = 32'h08000093;  // addi x1,x0,0x80
    dut.u_itcm.mem[1] = 32'h001000A3;  // sb x1,1(x0)
    dut.u_itcm.mem[2] = 32'h00100283;  // lb x5,1(x0)
    dut.u_itcm.mem[3] = 32'h00104303;  // lbu x6,1(x0)
    dut.u_itcm.mem[4] = 32'h00101123;  // sh x1,2(x0)
    dut.u_itcm.mem[5] = 32'h00201383;  // lh x7,2(x0)
    dut.u_itcm.mem[6] = 32'h00002403;  // lw x8,0(x0)
    release_rst();
    step(2);
    check("sb_word", dut.u_dtcm.mem[0], 32'h11228044);
    step(2);
    check("lb_sext", dut.u_core.rf[5], 32'hFFFFFF80);
    check("lbu_zext", dut.u_core.rf[6], 32'h00000080);
    step(1);
    check("sh_word", dut.u_dtcm.mem[0], 32'h00808044);
    step(2);
    check("lh_hi", dut.u_core.rf[7], 32'h00000080);
    check("lw_word", dut.u_core.rf[8], 32'h00808044);

    // JAL then JALR with an odd target
    begin_test();
    dut.u_itcm.mem[0] = 32'h008000EF;  // jal ra,+8
    dut.u_itcm.mem[2] = 32'h01100093;  // addi ra,x0,0x11
    dut.u_itcm.mem[3] = 32'h00008067;  // jalr x0,0(ra)
    release_rst();
    step(1);
    check("jal_ra", dut.u_core.rf[1], 32'h4);
    check("jal_pc", dbg_pc, 32'h8);
    step(2);
    check("jalr_pc", dbg_pc, 32'h10);

    // Store to the MMIO region
    begin_test();
    dut.u_dtcm.mem[0] = 32'hDEADBEEF;
    dut.u_itcm.mem[0] = 32'h100137b7;  // lui a5,0x10013
    dut.u_itcm.mem[1] = 32'h04100713;  // li a4,65
    dut.u_itcm.mem[2] = 32'h00E7A023;  // sw a4,0(a5)
    dut.u_itcm.mem[3] = 32'h0007A483;  // lw x9,0(a5)
    release_rst();
    mmio_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (mmio_we) mmio_pulses++;
      if (c == 2) begin
`ifdef QF_SOC_MMIO_EN
        check("mmio_we", {31'b0, mmio_we}, 32'h1);
        check("mmio_addr", mmio_addr, 32'h10013000);
        check("mmio_wdata", mmio_wdata, 32'd65);
`else
        check("mmio_we_off", {31'b0, mmio_we}, 32'h0);
        check("mmio_addr_off", mmio_addr, 32'h0);
`endif
      end
      step(1);
    end
`ifdef QF_SOC_MMIO_EN
    check("mmio_pulses", mmio_pulses, 32'd1);
    check("mmio_dtcm", dut.u_dtcm.mem[0], 32'hDEADBEEF);
    check("mmio_load", dut.u_core.rf[9], 32'h0);
`else
    check("mmio_pulses_off", mmio_pulses, 32'd0);
    check("mmio_dtcm_off", dut.u_dtcm.mem[0], 32'd65);
    check("mmio_load_off", dut.u_core.rf[9], 32'd65);
`endif

    // Reset asserted while a store executes
    begin_test();
    dut.u_dtcm.mem[0] = 32'hCAFEF00D;
    dut.u_itcm.mem[0] = 32'h05500093;  // addi x1,x0,0x55
    dut.u_itcm.mem[4] = 32'h00102023;  // sw x1,0(x0)
    release_rst();
    step(4);
    check("mid_pc_store", dbg_pc, 32'h10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_pc", dbg_pc, 32'h0);
    check("mid_dtcm", dut.u_dtcm.mem[0], 32'hCAFEF00D);
    for (int r = 0; r < 32; r++) check($sformatf("mid_rf%0d", r), dut.u_core.rf[r], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
